// File: rtl/iob_eth_tx_sched_pkg.sv
// Shared types and defaults for the Ethernet TX scheduler: FSM encoding, byte-count width, counter sizing.
package iob_eth_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_t;

  localparam int NB_W           = 11;
  localparam int DEF_MAX_NBYTES = 1500;
  localparam int DEF_IFG_CYCLES = 24;
  localparam int DEF_START_TO   = 64;

  // One counter serves both the start timeout and the inter-frame gap.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iob_eth_rr_arb.sv
// Round-robin picker: searches upward from ptr+1 with wrap; purely combinational, zero latency.
// No backpressure: the caller decides when to consume the winner and advance ptr.
module iob_eth_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld      = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_eth_tx_sched.sv
// Shares one Ethernet transmitter among N_REQ requesters: RR pick, send/start/complete sequencing, IFG.
// Grant follows a sampled request by one arbitration cycle; requesters hold req until their done/err pulse.
module iob_eth_tx_sched
  import iob_eth_tx_sched_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int MAX_NBYTES = DEF_MAX_NBYTES,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES,
  parameter int START_TO   = DEF_START_TO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [NB_W*N_REQ-1:0] req_nbytes,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic                  busy,
  output logic                  tx_send,
  output logic [NB_W-1:0]       tx_nbytes,
  input  logic                  tx_ready
);

  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW       = cnt_width(IFG_CYCLES, START_TO);
  localparam int TO_LAST  = (START_TO > 0) ? START_TO - 1 : 0;
  localparam int IFG_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  tx_state_t        state_q, state_d;
  logic             pend_q, pend_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] win_q, win_d;
  logic [NB_W-1:0]  nb_q, nb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_d, done_d, err_d;
  logic             send_d;

  logic [N_REQ-1:0] arb_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_vld;
  logic [NB_W-1:0]  nb_sel;

  iob_eth_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .win_vld (arb_vld)
  );

  always_comb begin
    nb_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) nb_sel = req_nbytes[NB_W*i +: NB_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 1'b0;
      ptr_q     <= IW'(N_REQ - 1);
      win_q     <= '0;
      nb_q      <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      tx_send   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      nb_q      <= nb_d;
      cnt_q     <= cnt_d;
      grant     <= grant_d;
      done      <= done_d;
      err       <= err_d;
      tx_send   <= send_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    done_d  = '0;
    err_d   = '0;
    send_d  = tx_send;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (int'(nb_q) > MAX_NBYTES) begin
            err_d = win_q;
          end else begin
            grant_d = win_q;
            send_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_START;
          end
        // Skip the cycle of an err pulse so the rejected requester can drop req first.
        end else if (arb_vld && tx_ready && (err == '0)) begin
          pend_d = 1'b1;
          win_d  = arb_oh;
          ptr_d  = arb_idx;
          nb_d   = nb_sel;
        end
      end

      ST_START: begin
        if (!tx_ready) begin
          send_d  = 1'b0;
          state_d = ST_RUN;
        end else if (cnt_q == CW'(TO_LAST)) begin
          send_d  = 1'b0;
          grant_d = '0;
          err_d   = win_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        if (tx_ready) begin
          done_d  = win_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end

      ST_GAP: begin
        if (cnt_q == CW'(IFG_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign tx_nbytes = nb_q;

endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// Bench for iob_eth_tx_sched: transmitter model plus scoreboard of expected grants and done/err pulses.
module tb_iob_eth_tx_sched;

  localparam int N        = 2;
  localparam int IFG      = 24;
  localparam int STO      = 64;
  localparam int MAXN     = 1500;
  localparam int SEND_LAT = 3;
  localparam int RUN_LEN  = 200;

  localparam int EV_DONE = 0;
  localparam int EV_REJ  = 1;
  localparam int EV_TO   = 2;

  typedef struct {
    int kind;
    int idx;
    int nbytes;
    int send_len;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [11*N-1:0] req_nbytes = '0;
  logic [N-1:0]    grant, done, err;
  logic            busy, tx_send;
  logic [10:0]     tx_nbytes;
  logic            tx_ready = 1'b1;

  logic            b_req = 1'b0;
  logic [10:0]     b_nbytes = '0;
  logic            b_grant, b_done, b_err, b_busy, b_tx_send;
  logic [10:0]     b_tx_nbytes;
  logic            b_tx_ready = 1'b1;

  always #5 clk = ~clk;

  iob_eth_tx_sched #(
    .N_REQ(N), .MAX_NBYTES(MAXN), .IFG_CYCLES(IFG), .START_TO(STO)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_nbytes(req_nbytes),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .tx_send(tx_send), .tx_nbytes(tx_nbytes), .tx_ready(tx_ready)
  );

  iob_eth_tx_sched #(
    .N_REQ(1), .MAX_NBYTES(MAXN), .IFG_CYCLES(0), .START_TO(8)
  ) u_dut_noifg (
    .clk(clk), .rst(rst), .req(b_req), .req_nbytes(b_nbytes),
    .grant(b_grant), .done(b_done), .err(b_err), .busy(b_busy),
    .tx_send(b_tx_send), .tx_nbytes(b_tx_nbytes), .tx_ready(b_tx_ready)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  sb_q[$];
  ev_t  mon_e;
  int   pend_frames[N];
  int   cyc = 0;
  int   send_cnt = 0;
  int   last_done_cyc = 0;
  logic gap_chk = 1'b0;
  logic gap_armed = 1'b0;
  logic [N-1:0] grant_prev = '0;
  logic stuck = 1'b0;
  int   scnt = 0;
  int   lcnt = 0;
  int   b_lcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic issue(input int i, input int nb, input int kind);
    ev_t e;
    e.kind     = kind;
    e.idx      = i;
    e.nbytes   = nb;
    e.send_len = (kind == EV_DONE) ? SEND_LAT : (kind == EV_TO) ? STO : 0;
    sb_q.push_back(e);
    req_nbytes[11*i +: 11] = 11'(nb);
    pend_frames[i]++;
  endtask

  task automatic wait_quiet(input string tag, input int limit);
    int ok;
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy && tx_ready) begin
        ok = 1;
        break;
      end
    end
    check_eq(tag, ok, 1);
  endtask

  // Main transmitter: drops ready SEND_LAT cycles into tx_send, raises it RUN_LEN cycles later.
  always @(negedge clk) begin
    if (stuck) begin
      tx_ready = 1'b1;
      scnt = 0;
    end else if (tx_ready) begin
      if (tx_send) begin
        scnt++;
        if (scnt == SEND_LAT) begin
          tx_ready = 1'b0;
          lcnt = 0;
          scnt = 0;
        end
      end else begin
        scnt = 0;
      end
    end else begin
      lcnt++;
      if (lcnt == RUN_LEN) tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (b_tx_ready) begin
      if (b_tx_send) begin
        b_tx_ready = 1'b0;
        b_lcnt = 0;
      end
    end else begin
      b_lcnt++;
      if (b_lcnt == 10) b_tx_ready = 1'b1;
    end
  end

  // Monitor, scoreboard and requester driver.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_send) send_cnt++;
      if (grant != '0 && grant_prev == '0) begin
        check_eq("grant_onehot", $onehot(grant), 1);
        check_eq("grant_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          check_eq("grant_idx", grant, 1 << sb_q[0].idx);
          check_eq("tx_nbytes", tx_nbytes, sb_q[0].nbytes);
          check_eq("grant_allowed", sb_q[0].kind != EV_REJ, 1);
        end
        if (gap_chk && gap_armed) check_eq("done_to_grant", cyc - last_done_cyc, IFG + 2);
        gap_armed = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (done[i] || err[i]) begin
          check_eq("grant_during_event", grant, 0);
          check_eq("event_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("event_idx", i, mon_e.idx);
            check_eq("event_done", done[i], mon_e.kind == EV_DONE);
            check_eq("event_err", err[i], mon_e.kind != EV_DONE);
            check_eq("send_cycles", send_cnt, mon_e.send_len);
          end
          send_cnt = 0;
          if (pend_frames[i] > 0) pend_frames[i]--;
          if (done[i]) begin
            last_done_cyc = cyc;
            gap_armed = 1'b1;
          end
        end
      end
    end
    grant_prev = grant;
    for (int i = 0; i < N; i++) req[i] = (pend_frames[i] > 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int n;
    for (int i = 0; i < N; i++) pend_frames[i] = 0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_send", tx_send, 0);
    check_eq("rst_tx_nbytes", tx_nbytes, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame, then the inter-frame gap.
    issue(0, 64, EV_DONE);
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done[0]) begin
        found = 1;
        break;
      end
    end
    check_eq("t1_done_seen", found, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("t1_ifg_cycles", n, IFG);
    wait_quiet("t1_quiet", 100);

    // Oversized request on requester 1 is rejected without a grant.
    issue(1, 1501, EV_REJ);
    wait_quiet("t3_quiet", 100);

    // Both requesting: RR pointer now at 1, so service order is 0,1,0,1.
    gap_armed = 1'b0;
    gap_chk = 1'b1;
    issue(0, 100, EV_DONE);
    issue(1, 1200, EV_DONE);
    issue(0, 100, EV_DONE);
    issue(1, 1200, EV_DONE);
    wait_quiet("t2_quiet", 2000);
    gap_chk = 1'b0;

    // Transmitter never starts: timeout error, then the next request is served.
    stuck = 1'b1;
    issue(0, 1500, EV_TO);
    wait_quiet("t4_to_quiet", 300);
    stuck = 1'b0;
    @(negedge clk);
    issue(1, 0, EV_DONE);
    wait_quiet("t4_next_quiet", 600);

    // Reset during RUN aborts the frame silently.
    issue(0, 300, EV_DONE);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (grant[0] && !tx_send) begin
        found = 1;
        break;
      end
    end
    check_eq("t5_run_reached", found, 1);
    rst = 1'b1;
    sb_q.delete();
    for (int i = 0; i < N; i++) pend_frames[i] = 0;
    @(negedge clk);
    check_eq("t5_grant", grant, 0);
    check_eq("t5_tx_send", tx_send, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done", done, 0);
    rst = 1'b0;
    send_cnt = 0;
    repeat (RUN_LEN + 20) @(negedge clk);
    check_eq("t5_idle_after", busy, 0);

    // IFG_CYCLES=0 build: req dropped mid-RUN still completes; next grant follows done directly.
    b_nbytes = 11'd40;
    b_req = 1'b1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_grant && !b_tx_send) begin
        found = 1;
        break;
      end
    end
    check_eq("t6_run_reached", found, 1);
    check_eq("t6_tx_nbytes", b_tx_nbytes, 40);
    b_req = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_done) begin
        found = 1;
        break;
      end
    end
    check_eq("t6_done_after_drop", found, 1);
    b_req = 1'b1;
    b_nbytes = 11'd0;
    n = 0;
    while (!b_grant && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_no_gap", n, 2);
    check_eq("t6_tx_nbytes_zero", b_tx_nbytes, 0);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_done) begin
        found = 1;
        break;
      end
    end
    b_req = 1'b0;
    check_eq("t6_second_done", found, 1);
    check_eq("t6_no_err", b_err, 0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
